// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with 16x (configurable) oversampling.
//
// The asynchronous rx pin is brought into the clk domain through a two-flop
// synchroniser. A start bit is confirmed at its middle. Each following bit is
// then sampled once per bit period, also at mid-bit. A completed byte is held,
// together with its status flags, until the core pops it with rd_en.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> 8E1 frames. One even-parity bit follows data bit 7 and is
//                checked into parity_err.
//   undefined -> 8N1 frames. parity_err is tied to 0.
//
// Parameters
//   CLK_FREQ    system clock frequency in Hz
//   BAUD_RATE   line rate in bits/s
//   OVERSAMPLE  sample ticks per bit (even, >= 8)
//
// Ports
//   clk         system clock; all logic runs on posedge
//   rst         synchronous, active-high reset
//   rx          asynchronous serial input, idle high
//   rd_en       pop the held byte; ignored while read_ready = 0
//   data        held byte, LSB = first bit received
//   read_ready  held byte valid
//   frame_err   held byte was received with stop bit = 0
//   overrun     sticky: a byte was dropped because the holding register was full
//   busy        a frame is being received
//   parity_err  held byte failed even parity (parity build only, else 0)

module uart_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] data,
    output logic       read_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy,
    output logic       parity_err
);

    // Clocks per oversample tick. Clamped to 1 so that very slow system clocks
    // still produce a tick on every cycle.
    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SAMP_HALF = SW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          brk;
    logic          brk_nxt;

    logic          rx_meta;
    logic          rx_s;

    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] samp_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;

    logic          tick;
    logic          half_smp;
    logic          bit_smp;
    logic          frame_done;
    logic          load;
    logic          drop;
    logic          pop;

    // Two-flop synchroniser. Both flops reset to the idle line level so that
    // reset does not look like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Oversample tick. The counter is held at 0 in IDLE, so every frame starts
    // with a freshly aligned tick phase.
    assign tick     = (state != IDLE) && (tick_cnt == TICK_LAST);
    assign half_smp = tick && (samp_cnt == SAMP_HALF);
    assign bit_smp  = tick && (samp_cnt == SAMP_LAST);

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Ticks within the current bit. In START the counter wraps at half a bit,
    // so that every later sample lands in the middle of its bit.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            samp_cnt <= '0;
        end else if ((state == START) ? half_smp : bit_smp) begin
            samp_cnt <= '0;
        end else if (tick) begin
            samp_cnt <= samp_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            bit_cnt <= '0;
            shift   <= '0;
        end else if (state == DATA && bit_smp) begin
            bit_cnt <= bit_cnt + 1'b1;
            shift   <= {rx_s, shift[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic par_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit <= 1'b0;
        end else if (state == PARITY && bit_smp) begin
            par_bit <= rx_s;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            brk   <= 1'b0;
        end else begin
            state <= state_nxt;
            brk   <= brk_nxt;
        end
    end

    // brk marks a frame whose stop bit was 0. The frame has already been
    // delivered, but the receiver stays in STOP until the line returns high.
    // This keeps a held-low line from being read as a string of zero bytes.
    always_comb begin
        state_nxt = state;
        brk_nxt   = brk;
        case (state)
            IDLE: begin
                brk_nxt = 1'b0;
                if (!rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (half_smp) begin
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_smp && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_smp) begin
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (brk) begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                        brk_nxt   = 1'b0;
                    end
                end else if (bit_smp) begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end else begin
                        brk_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                brk_nxt   = 1'b0;
            end
        endcase
    end

    // A pop on the completion cycle frees the holding register in time for
    // the new byte, so that case loads instead of overrunning.
    assign frame_done = (state == STOP) && !brk && bit_smp;
    assign pop        = rd_en && read_ready;
    assign load       = frame_done && (!read_ready || rd_en);
    assign drop       = frame_done && read_ready && !rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            data       <= '0;
            read_ready <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load) begin
                data       <= shift;
                read_ready <= 1'b1;
                frame_err  <= ~rx_s;
            end else if (pop) begin
                read_ready <= 1'b0;
                frame_err  <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (pop) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else if (load) begin
            par_err_q <= (^shift) ^ par_bit;
        end else if (pop) begin
            par_err_q <= 1'b0;
        end
    end

    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule
